// File: rtl/regfile_mp.sv
// Purpose : multi-read-port register file with a per-register busy scoreboard
// Latency : reads are combinational (0 cycles); writes and busy updates land on the next rising clk
// Backpr. : none; every write/issue strobe is accepted in the cycle it is presented
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   rd_addr/rd_data/rd_busy NUM_RD packed read ports (address, data, busy flag)
//   wr_en/wr_addr/wr_data   writeback port; clears busy of the written register
//   issue_en/issue_addr     decode issue port; marks destination register busy
//   busy_vec                full scoreboard, bit r = register r has an outstanding write
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*XLEN-1:0]   rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [XLEN-1:0]          wr_data,
  input  logic                     issue_en,
  input  logic [AW-1:0]            issue_addr,
  output logic [NREGS-1:0]         busy_vec
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             wr_ok;
  logic             issue_ok;

  // Register 0 swallows writes and issues when it is hardwired to zero, so its
  // storage and busy bit never leave their reset value.
  always_comb begin
    wr_ok    = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
    issue_ok = issue_en && !((ZERO_REG != 0) && (issue_addr == '0));
    regs_d   = regs_q;
    busy_d   = busy_q;
    if (wr_ok) begin
      regs_d[wr_addr] = wr_data;
      busy_d[wr_addr] = 1'b0;
    end
    // Applied after the write so a new producer supersedes the completing one.
    if (issue_ok) begin
      busy_d[issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            busy;

    assign addr = rd_addr[i*AW +: AW];

    always_comb begin
      data = regs_q[addr];
      busy = busy_q[addr];
      // Forwarding is suppressed during reset so reads show the cleared state.
      if ((BYPASS != 0) && wr_en && !reset && (addr == wr_addr)) begin
        data = wr_data;
        busy = 1'b0;
      end
      if ((ZERO_REG != 0) && (addr == '0)) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign rd_data[i*XLEN +: XLEN] = data;
    assign rd_busy[i]              = busy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  // Instance A: XLEN=32, NREGS=32, NUM_RD=2, BYPASS=1, ZERO_REG=1
  // Instance B: XLEN=64, NREGS=16, NUM_RD=4, BYPASS=0, ZERO_REG=0
  typedef struct packed {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        ien;
    logic [4:0]  iaddr;
    logic [9:0]  raddr;
  } a_stim_t;

  typedef struct packed {
    logic        wen;
    logic [3:0]  waddr;
    logic [63:0] wdata;
    logic        ien;
    logic [3:0]  iaddr;
    logic [15:0] raddr;
  } b_stim_t;

  typedef struct packed {
    logic [63:0]  a_data;
    logic [1:0]   a_busy;
    logic [31:0]  a_bv;
    logic [255:0] b_data;
    logic [3:0]   b_busy;
    logic [15:0]  b_bv;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic [9:0]   a_rd_addr;
  logic [63:0]  a_rd_data;
  logic [1:0]   a_rd_busy;
  logic         a_wr_en;
  logic [4:0]   a_wr_addr;
  logic [31:0]  a_wr_data;
  logic         a_issue_en;
  logic [4:0]   a_issue_addr;
  logic [31:0]  a_busy_vec;

  logic [15:0]  b_rd_addr;
  logic [255:0] b_rd_data;
  logic [3:0]   b_rd_busy;
  logic         b_wr_en;
  logic [3:0]   b_wr_addr;
  logic [63:0]  b_wr_data;
  logic         b_issue_en;
  logic [3:0]   b_issue_addr;
  logic [15:0]  b_busy_vec;

  // Reference model: plain storage plus a set of registers awaiting a write.
  logic [31:0] ma_mem [32];
  logic [31:0] ma_bsy;
  logic [63:0] mb_mem [16];
  logic [15:0] mb_bsy;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clk(clk), .reset(rst),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .issue_en(a_issue_en), .issue_addr(a_issue_addr), .busy_vec(a_busy_vec)
  );

  regfile_mp #(.XLEN(64), .NREGS(16), .NUM_RD(4), .BYPASS(0), .ZERO_REG(0)) dut_b (
    .clk(clk), .reset(rst),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .issue_en(b_issue_en), .issue_addr(b_issue_addr), .busy_vec(b_busy_vec)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, req);
    end
  endtask

  // Monitor: compares whatever the DUTs present against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("a_rd_data",  256'(a_rd_data),  256'(e.a_data));
      chk("a_rd_busy",  256'(a_rd_busy),  256'(e.a_busy));
      chk("a_busy_vec", 256'(a_busy_vec), 256'(e.a_bv));
      chk("b_rd_data",  b_rd_data,        e.b_data);
      chk("b_rd_busy",  256'(b_rd_busy),  256'(e.b_busy));
      chk("b_busy_vec", 256'(b_busy_vec), 256'(e.b_bv));
    end
  end

  function automatic a_stim_t a_st(input logic wen, input int waddr, input logic [31:0] wdata,
                                   input logic ien, input int iaddr, input int r0, input int r1);
    a_stim_t s;
    s.wen = wen; s.waddr = 5'(waddr); s.wdata = wdata;
    s.ien = ien; s.iaddr = 5'(iaddr);
    s.raddr = {5'(r1), 5'(r0)};
    return s;
  endfunction

  function automatic b_stim_t b_st(input logic wen, input int waddr, input logic [63:0] wdata,
                                   input logic ien, input int iaddr,
                                   input int r0, input int r1, input int r2, input int r3);
    b_stim_t s;
    s.wen = wen; s.waddr = 4'(waddr); s.wdata = wdata;
    s.ien = ien; s.iaddr = 4'(iaddr);
    s.raddr = {4'(r3), 4'(r2), 4'(r1), 4'(r0)};
    return s;
  endfunction

  // Small addresses are favoured so collisions between ports are frequent.
  function automatic int ra_a();
    return ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 31));
  endfunction

  function automatic int ra_b();
    return ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
  endfunction

  function automatic a_stim_t rand_a();
    return a_st(1'($urandom_range(0, 1)), ra_a(), $urandom, 1'($urandom_range(0, 1)), ra_a(),
                ra_a(), ra_a());
  endfunction

  function automatic b_stim_t rand_b();
    return b_st(1'($urandom_range(0, 1)), ra_b(), {$urandom, $urandom},
                1'($urandom_range(0, 1)), ra_b(), ra_b(), ra_b(), ra_b(), ra_b());
  endfunction

  // Apply the rising edge that consumed the inputs currently on the ports.
  task automatic commit();
    if (a_wr_en) begin
      if (a_wr_addr != 0) ma_mem[a_wr_addr] = a_wr_data;
      ma_bsy[a_wr_addr] = 1'b0;
    end
    if (a_issue_en && a_issue_addr != 0) ma_bsy[a_issue_addr] = 1'b1;
    if (b_wr_en) begin
      b_mem_write: mb_mem[b_wr_addr] = b_wr_data;
      mb_bsy[b_wr_addr] = 1'b0;
    end
    if (b_issue_en) mb_bsy[b_issue_addr] = 1'b1;
  endtask

  task automatic clear_model();
    for (int r = 0; r < 32; r++) ma_mem[r] = '0;
    for (int r = 0; r < 16; r++) mb_mem[r] = '0;
    ma_bsy = '0;
    mb_bsy = '0;
  endtask

  task automatic cycle(input logic r, input a_stim_t sa, input b_stim_t sb);
    exp_t e;
    @(posedge clk);
    if (!rst) commit();
    #1;
    rst          = r;
    a_wr_en      = sa.wen;   a_wr_addr    = sa.waddr; a_wr_data = sa.wdata;
    a_issue_en   = sa.ien;   a_issue_addr = sa.iaddr; a_rd_addr = sa.raddr;
    b_wr_en      = sb.wen;   b_wr_addr    = sb.waddr; b_wr_data = sb.wdata;
    b_issue_en   = sb.ien;   b_issue_addr = sb.iaddr; b_rd_addr = sb.raddr;
    if (r) clear_model();
    e = '0;
    for (int p = 0; p < 2; p++) begin
      int x;
      x = int'(a_rd_addr[p*5 +: 5]);
      if (r || x == 0) begin
        e.a_data[p*32 +: 32] = '0;
        e.a_busy[p]          = 1'b0;
      end else if (a_wr_en && int'(a_wr_addr) == x) begin
        e.a_data[p*32 +: 32] = a_wr_data;
        e.a_busy[p]          = 1'b0;
      end else begin
        e.a_data[p*32 +: 32] = ma_mem[x];
        e.a_busy[p]          = ma_bsy[x];
      end
    end
    e.a_bv = ma_bsy;
    for (int p = 0; p < 4; p++) begin
      int x;
      x = int'(b_rd_addr[p*4 +: 4]);
      e.b_data[p*64 +: 64] = mb_mem[x];
      e.b_busy[p]          = mb_bsy[x];
    end
    e.b_bv = mb_bsy;
    exp_q.push_back(e);
  endtask

  a_stim_t ai;
  b_stim_t bi;

  initial begin
    rst = 1'b1;
    a_wr_en = 0; a_wr_addr = 0; a_wr_data = 0; a_issue_en = 0; a_issue_addr = 0; a_rd_addr = 0;
    b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0; b_issue_en = 0; b_issue_addr = 0; b_rd_addr = 0;
    clear_model();
    ai = '0;
    bi = '0;

    // Reset state
    cycle(1, a_st(0, 0, 0, 0, 0, 5, 3), b_st(0, 0, 0, 0, 0, 1, 2, 3, 4));
    cycle(1, ai, bi);

    // Write/read on both ports, then same-cycle bypass
    cycle(0, a_st(1, 3, 32'h12345678, 0, 0, 3, 3), rand_b());
    cycle(0, a_st(0, 0, 0, 0, 0, 3, 3), rand_b());
    cycle(0, a_st(1, 3, 32'hCAFEF00D, 0, 0, 3, 5), rand_b());
    cycle(0, a_st(0, 0, 0, 0, 0, 3, 3), rand_b());

    // Reset asserted mid-operation with a write and an issue in flight
    cycle(0, a_st(1, 5, 32'hDEADBEEF, 1, 8, 5, 8), rand_b());
    cycle(0, a_st(0, 0, 0, 0, 0, 5, 8), rand_b());
    cycle(1, a_st(1, 6, 32'h66666666, 1, 7, 5, 6), rand_b());
    cycle(0, a_st(0, 0, 0, 0, 0, 5, 6), rand_b());

    // Hardwired zero register
    cycle(0, a_st(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0), rand_b());
    cycle(0, a_st(0, 0, 0, 0, 0, 0, 0), rand_b());

    // Scoreboard set, bypassed clear, and clear visible next cycle
    cycle(0, a_st(0, 0, 0, 1, 7, 7, 7), rand_b());
    cycle(0, a_st(0, 0, 0, 0, 0, 7, 0), rand_b());
    cycle(0, a_st(1, 7, 32'h00000077, 0, 0, 7, 7), rand_b());
    cycle(0, a_st(0, 0, 0, 0, 0, 7, 7), rand_b());

    // Issue and write to the same busy register in one cycle
    cycle(0, a_st(0, 0, 0, 1, 9, 9, 9), rand_b());
    cycle(0, a_st(1, 9, 32'h00000055, 1, 9, 9, 9), rand_b());
    cycle(0, a_st(0, 0, 0, 0, 0, 9, 9), rand_b());

    // Wide four-port instance: distinct registers, no forwarding, ordinary reg 0
    cycle(1, ai, bi);
    cycle(0, ai, b_st(1, 0, 64'hFFFFFFFFFFFFFFFF, 0, 0, 0, 0, 0, 0));
    cycle(0, ai, b_st(1, 1, 64'h1111111111111111, 1, 4, 0, 1, 2, 3));
    cycle(0, ai, b_st(1, 2, 64'h2222222222222222, 0, 0, 0, 1, 2, 3));
    cycle(0, ai, b_st(1, 3, 64'h3333333333333333, 0, 0, 3, 2, 1, 0));
    cycle(0, ai, b_st(1, 1, 64'hABCDABCDABCDABCD, 0, 0, 1, 1, 4, 3));
    cycle(0, ai, b_st(0, 0, 0, 0, 0, 1, 2, 3, 4));

    // Randomised traffic with occasional reset
    for (int n = 0; n < 800; n++) begin
      cycle(($urandom_range(0, 63) == 0), rand_a(), rand_b());
    end
    cycle(0, ai, bi);

    repeat (2) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
